// File: rtl/bp_me_io_cmd_arbiter.sv
// N-source round-robin IO command arbiter with an in-order response router.
// An order FIFO of grant indices steers each response back to its issuing source.
module bp_me_io_cmd_arbiter #(
  parameter int num_src_p   = 2,
  parameter int msg_width_p = 576,
  parameter int els_p       = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_src_p-1:0]             src_en_i,
  input  logic [num_src_p*msg_width_p-1:0] src_cmd_i,
  input  logic [num_src_p-1:0]             src_cmd_v_i,
  output logic [num_src_p-1:0]             src_cmd_yumi_o,
  output logic [msg_width_p-1:0]           src_resp_o,
  output logic [num_src_p-1:0]             src_resp_v_o,
  input  logic [num_src_p-1:0]             src_resp_ready_and_i,
  output logic [msg_width_p-1:0]           io_cmd_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_ready_and_i,
  input  logic [msg_width_p-1:0]           io_resp_i,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_yumi_o,
  output logic [$clog2(els_p+1)-1:0]       outstanding_o,
  output logic                             error_o
);

  localparam int lg_src_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
  localparam int ptr_w_lp  = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp  = $clog2(els_p + 1);

  typedef logic [lg_src_lp-1:0] src_idx_t;
  typedef logic [ptr_w_lp-1:0]  ptr_t;
  typedef logic [cnt_w_lp-1:0]  cnt_t;

  localparam cnt_t     els_lp       = cnt_t'(els_p);
  localparam ptr_t     ptr_last_lp  = ptr_t'(els_p - 1);
  localparam src_idx_t last_src_lp  = src_idx_t'(num_src_p - 1);

  src_idx_t last_grant_q, last_grant_d;
  src_idx_t mem_q [els_p];
  src_idx_t mem_d [els_p];
  ptr_t     wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t     count_q, count_d;
  logic     error_q, error_d;

  logic [num_src_p-1:0]   eligible;
  logic [msg_width_p-1:0] cmd_arr [num_src_p];
  src_idx_t               grant, head;
  logic                   any_eligible, accept, fifo_empty, pop;
  int                     cand;

  // Round-robin search starts just after the last accepted source.
  always_comb begin
    eligible     = src_en_i & src_cmd_v_i;
    grant        = '0;
    any_eligible = 1'b0;
    cand         = 0;
    for (int i = 1; i <= num_src_p; i++) begin
      cand = int'(last_grant_q) + i;
      if (cand >= num_src_p) cand = cand - num_src_p;
      if (!any_eligible && eligible[src_idx_t'(cand)]) begin
        any_eligible = 1'b1;
        grant        = src_idx_t'(cand);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < num_src_p; i++) begin
      cmd_arr[i] = src_cmd_i[i*msg_width_p +: msg_width_p];
    end
  end

  always_comb begin
    fifo_empty     = (count_q == '0);
    head           = mem_q[rptr_q];
    io_cmd_o       = cmd_arr[grant];
    io_cmd_v_o     = !reset_i && any_eligible && (count_q < els_lp);
    accept         = io_cmd_v_o && io_cmd_ready_and_i;
    src_resp_o     = io_resp_i;
    io_resp_yumi_o = !reset_i && io_resp_v_i
                     && (fifo_empty || src_resp_ready_and_i[head]);
    pop            = io_resp_yumi_o && !fifo_empty;
    src_cmd_yumi_o = '0;
    src_resp_v_o   = '0;
    for (int i = 0; i < num_src_p; i++) begin
      src_cmd_yumi_o[i] = accept && (grant == src_idx_t'(i));
      src_resp_v_o[i]   = !reset_i && io_resp_v_i && !fifo_empty
                          && (head == src_idx_t'(i));
    end
    outstanding_o = count_q;
    error_o       = error_q;
  end

  // Occupancy never bypasses at full: push depends only on count_q.
  always_comb begin
    mem_d        = mem_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    error_d      = error_q || (io_resp_v_i && fifo_empty);
    if (accept) begin
      mem_d[wptr_q] = grant;
      wptr_d        = (wptr_q == ptr_last_lp) ? '0 : wptr_q + 1'b1;
      last_grant_d  = grant;
    end
    if (pop) begin
      rptr_d = (rptr_q == ptr_last_lp) ? '0 : rptr_q + 1'b1;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      last_grant_q <= last_src_lp;
      error_q      <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: doc/bp_me_io_cmd_arbiter.md
# bp_me_io_cmd_arbiter

Parametrised N-source IO command arbiter and response router for the tethered test harness. It merges IO command streams from several masters onto one BedRock IO command port: NBF loader, host, Ethernet bridge, and any future sources. Each in-order IO response is returned to the master that issued the matching command. It generalises the current fixed pair of separate NBF/host IO ports: any number of sources, a bounded outstanding window, per-source enables and protocol-error detection.

## Interface
- num_src_p, 2: number of command sources (≥1)
- msg_width_p, 576: width of a packed BedRock IO message (header+data)
- els_p, 8: maximum outstanding commands (≥1); depth of the order FIFO
- clk_i  in  1  single clock
- reset_i  in  1  reset, asynchronous, active-high
- src_en_i  in  num_src_p  per-source arbitration enable; 0 masks that source from grant
- src_cmd_i  in  num_src_p×msg_width_p  per-source command
- src_cmd_v_i  in  num_src_p  per-source command valid
- src_cmd_yumi_o  out  num_src_p  per-source command consumed (valid-yumi)
- src_resp_o  out  msg_width_p  response payload, broadcast to all sources
- src_resp_v_o  out  num_src_p  one-hot response valid for the destination source
- src_resp_ready_and_i  in  num_src_p  per-source response ready
- io_cmd_o  out  msg_width_p  merged command
- io_cmd_v_o  out  1  merged command valid
- io_cmd_ready_and_i  in  1  downstream ready
- io_resp_i  in  msg_width_p  downstream response
- io_resp_v_i  in  1  downstream response valid
- io_resp_yumi_o  out  1  downstream response consumed
- outstanding_o  out  $clog2(els_p+1)  commands issued and not yet answered
- error_o  out  1  sticky: a response arrived with no outstanding command

## Operation
- Eligible source s: src_cmd_v_i[s] & src_en_i[s].
- Round-robin arbitration. The search starts at last_grant+1 and wraps modulo num_src_p. The grant is combinational from the eligible set and last_grant.
- Issue allowed when any source is eligible and outstanding_o < els_p.
- io_cmd_v_o = issue allowed; io_cmd_o = src_cmd_i[grant].
- Accept = io_cmd_v_o & io_cmd_ready_and_i. On accept:
  - src_cmd_yumi_o[grant]=1 in the same cycle; all other yumi bits are 0.
  - Grant index is pushed into the order FIFO.
  - last_grant <= grant.
- last_grant does not update without accept, so the grant may change between cycles while ready is low.
- Response destination d = order FIFO head.
- FIFO non-empty:
  - src_resp_v_o = io_resp_v_i ? onehot(d) : 0; src_resp_o = io_resp_i.
  - io_resp_yumi_o = io_resp_v_i & src_resp_ready_and_i[d]. On yumi, the FIFO pops.
- FIFO empty and io_resp_v_i=1:
  - Unsolicited response. io_resp_yumi_o=1 (drained), src_resp_v_o=0, error_o <= 1.
- outstanding_o = FIFO occupancy.
  - Push only: +1. Pop only: −1. Simultaneous push and pop: unchanged.
- A push is allowed in the cycle a pop frees the last slot only if outstanding_o < els_p at cycle start. There is no same-cycle bypass at full.
- A disabled source with valid asserted is never granted. Its already-outstanding responses are still delivered.
- Responses are strictly in order. Downstream guarantees IO responses return in command order.

## Timing
- Command path: zero-cycle combinational (src_cmd → io_cmd, io_cmd_ready_and_i → src_cmd_yumi_o).
- Response path: zero-cycle combinational (io_resp → src_resp, src_resp_ready_and_i → io_resp_yumi_o).
- State elements: order FIFO (els_p × $clog2(num_src_p)), occupancy counter, last_grant, error flag.
- Reset values:
  - outstanding_o=0, FIFO empty, error_o=0.
  - last_grant=num_src_p−1, so source 0 has first priority.
  - All v/yumi outputs 0 while reset_i=1.
- Reset mid-operation discards all outstanding state. A later response to a pre-reset command is treated as unsolicited and sets error_o. Integrators quiesce before reset.
- error_o clears only on reset.
- Throughput: one command and one response per cycle, concurrently.

## Test plan
- Single source, els_p=8, downstream always ready, 8 back-to-back commands with responses held off:
  - 8 yumis on consecutive cycles; outstanding_o reaches 8; io_cmd_v_o=0 with a 9th pending.
  - Release one response → 9th issues the next cycle.
- num_src_p=3, all valid continuously, ready=1:
  - Grants 0,1,2,0,1,2. Each response is routed one-hot to 1,2,4,1,2,4 in issue order.
- Source 1 stalls src_resp_ready_and_i=0 for 5 cycles while the head response is destined to 1:
  - io_resp_yumi_o=0 for 5 cycles; later responses for source 0 wait; outstanding_o unchanged.
- Simultaneous accept and response at outstanding_o=3:
  - outstanding_o stays 3; FIFO head advances; new tail equals the granted source.
- src_en_i=3'b101 with all three valid:
  - Grants alternate 0,2,0,2. Source 1 is never yumi'd until its enable is set, then granted in its round-robin turn.
- io_resp_v_i=1 with nothing outstanding:
  - io_resp_yumi_o=1, no src_resp_v_o, error_o=1 and held.
  - Assert reset_i asynchronously mid-burst → error_o=0, outstanding_o=0 immediately.
